// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single BRAM port between the RISC-V Processor (default
//   priority) and a secondary bus master (DMA / debug loader).
//
//   Build option: ARB_STARVE_EN
//     defined   : a starvation counter lets a waiting DMA steal one CPU slot
//                 once it has waited STARVE_LIMIT cycles. The colliding CPU
//                 access is held and replayed the following cycle, with the
//                 CPU stalled through cpu_rbusy / cpu_wbusy.
//     undefined : the DMA is strictly lowest priority. It is granted only on
//                 cycles with no CPU access, and the busy flags are tied low.
//
//   Ports
//     clk, resetn          clock, synchronous active-low reset
//     cpu_*                Processor side (addr, rstrb, wdata, wmask in;
//                          rdata, rbusy, wbusy out)
//     dma_*                secondary master (req, we, addr, wdata, wmask in;
//                          gnt, rvalid, rdata out)
//     mem_*                Memory side (addr, rstrb, wdata, wmask out;
//                          rdata in, valid the cycle after mem_rstrb)
//
//   Every driven output except the two rdata pass-throughs is forced to 0
//   while resetn is low.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rstrb,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rbusy,
  output logic        cpu_wbusy,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_wmask,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_CPU,
    SLOT_DMA,
    SLOT_REPLAY
  } slot_e;

  slot_e slot;
  logic  cpu_act;
  logic  dma_rd_q, dma_rd_d;

  assign cpu_act    = cpu_rstrb | (|cpu_wmask);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign dma_rd_d   = (slot == SLOT_DMA) & ~dma_we;
  assign dma_rvalid = resetn & dma_rd_q;

`ifdef ARB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic        replay_q, replay_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;
  logic [3:0]  hold_wmask_q, hold_wmask_d;
  logic        hold_is_read_q, hold_is_read_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;

  // A pending replay always wins; CPU inputs during that cycle are ignored
  // because the CPU is stalled and must not issue.
  always_comb begin
    slot = SLOT_CPU;
    if (!resetn) begin
      slot = SLOT_NONE;
    end else if (replay_q) begin
      slot = SLOT_REPLAY;
    end else if (dma_req && (!cpu_act || starve_cnt_q == LIMIT)) begin
      slot = SLOT_DMA;
    end
  end

  always_comb begin
    replay_d       = (slot == SLOT_DMA) & cpu_act;
    hold_addr_d    = hold_addr_q;
    hold_wdata_d   = hold_wdata_q;
    hold_wmask_d   = hold_wmask_q;
    hold_is_read_d = hold_is_read_q;
    if (replay_d) begin
      hold_addr_d    = cpu_addr;
      hold_wdata_d   = cpu_wdata;
      hold_wmask_d   = cpu_wmask;
      hold_is_read_d = cpu_rstrb;
    end

    if (!dma_req || slot == SLOT_DMA) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q == LIMIT) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      replay_q       <= 1'b0;
      hold_addr_q    <= '0;
      hold_wdata_q   <= '0;
      hold_wmask_q   <= '0;
      hold_is_read_q <= 1'b0;
      starve_cnt_q   <= '0;
    end else begin
      replay_q       <= replay_d;
      hold_addr_q    <= hold_addr_d;
      hold_wdata_q   <= hold_wdata_d;
      hold_wmask_q   <= hold_wmask_d;
      hold_is_read_q <= hold_is_read_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign cpu_rbusy = resetn & replay_q & hold_is_read_q;
  assign cpu_wbusy = resetn & replay_q & ~hold_is_read_q;
`else
  // The limit only matters when the steal path is built in.
  logic [7:0] unused_limit;
  assign unused_limit = 8'(STARVE_LIMIT);

  always_comb begin
    slot = SLOT_CPU;
    if (!resetn) begin
      slot = SLOT_NONE;
    end else if (dma_req && !cpu_act) begin
      slot = SLOT_DMA;
    end
  end

  assign cpu_rbusy = 1'b0;
  assign cpu_wbusy = 1'b0;
`endif

  // Memory port mux. An idle CPU pass-through naturally drives rstrb/wmask 0.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    dma_gnt   = 1'b0;
    case (slot)
      SLOT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rstrb = cpu_rstrb;
        mem_wmask = cpu_wmask;
      end
      SLOT_DMA: begin
        dma_gnt   = 1'b1;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_rstrb = ~dma_we;
        mem_wmask = dma_we ? dma_wmask : 4'h0;
      end
`ifdef ARB_STARVE_EN
      SLOT_REPLAY: begin
        mem_addr  = hold_addr_q;
        mem_wdata = hold_wdata_q;
        mem_rstrb = hold_is_read_q;
        mem_wmask = hold_wmask_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dma_rd_q <= 1'b0;
    end else begin
      dma_rd_q <= dma_rd_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned LIMIT = 4;
`ifdef ARB_STARVE_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] cpu_addr;
  logic        cpu_rstrb;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_rdata;
  logic        cpu_rbusy;
  logic        cpu_wbusy;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wmask;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_addr  (cpu_addr),
    .cpu_rstrb (cpu_rstrb),
    .cpu_wdata (cpu_wdata),
    .cpu_wmask (cpu_wmask),
    .cpu_rdata (cpu_rdata),
    .cpu_rbusy (cpu_rbusy),
    .cpu_wbusy (cpu_wbusy),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_wmask (dma_wmask),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // BRAM behaviour: registered read, byte-masked write.
  logic [31:0] bram [0:255];
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= bram[mem_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) bram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  logic [31:0] ref_mem [0:255];

  task automatic drive_idle();
    cpu_addr  = '0; cpu_rstrb = 1'b0; cpu_wdata = '0; cpu_wmask = '0;
    dma_req   = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_wmask = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cpu_rstrb = 1'b1; cpu_wmask = 4'hF; cpu_addr = 32'h44; cpu_wdata = 32'hA5A5A5A5;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h88; dma_wdata = '1; dma_wmask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({mem_addr, mem_wdata, mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy} !== '0) begin
        bad++;
        $display("FAIL reset_outputs c%0d: got addr=%h wdata=%h rstrb=%b wmask=%h gnt=%b rvalid=%b rbusy=%b wbusy=%b want all 0",
                 i, mem_addr, mem_wdata, mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy);
      end
      @(negedge clk);
    end
    drive_idle();
    resetn = 1'b1;
    #1;
    total++;
    if ({mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy} !== '0) begin
      bad++;
      $display("FAIL reset_release_idle: got rstrb=%b wmask=%h gnt=%b rvalid=%b busy=%b%b want 0",
               mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy);
    end
    @(negedge clk);
  endtask

  task automatic test_cpu_only();
    drive_idle();
    cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; cpu_wmask = 4'hF;
    #1;
    total++;
    if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF || mem_wmask !== 4'hF || mem_rstrb !== 1'b0) begin
      bad++;
      $display("FAIL cpu_write_pass: got addr=%h wdata=%h wmask=%h rstrb=%b want 40/deadbeef/f/0",
               mem_addr, mem_wdata, mem_wmask, mem_rstrb);
    end
    @(negedge clk);
    cpu_wmask = 4'h0; cpu_rstrb = 1'b1;
    #1;
    total++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h40 || cpu_rbusy !== 1'b0) begin
      bad++;
      $display("FAIL cpu_read_pass: got rstrb=%b addr=%h rbusy=%b want 1/40/0", mem_rstrb, mem_addr, cpu_rbusy);
    end
    @(negedge clk);
    drive_idle();
    #1;
    total++;
    if (cpu_rdata !== 32'hDEADBEEF || cpu_rbusy !== 1'b0 || cpu_wbusy !== 1'b0) begin
      bad++;
      $display("FAIL cpu_read_data: got rdata=%h busy=%b%b want deadbeef/00", cpu_rdata, cpu_rbusy, cpu_wbusy);
    end
    @(negedge clk);
  endtask

  task automatic test_dma_only();
    drive_idle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h12345678; dma_wmask = 4'hF;
    #1;
    total++;
    if (dma_gnt !== 1'b1 || mem_wmask !== 4'hF || mem_rstrb !== 1'b0 || mem_addr !== 32'h80 || mem_wdata !== 32'h12345678) begin
      bad++;
      $display("FAIL dma_write_issue: got gnt=%b wmask=%h rstrb=%b addr=%h wdata=%h want 1/f/0/80/12345678",
               dma_gnt, mem_wmask, mem_rstrb, mem_addr, mem_wdata);
    end
    @(negedge clk);
    dma_we = 1'b0;
    #1;
    total++;
    if (dma_gnt !== 1'b1 || mem_rstrb !== 1'b1 || mem_wmask !== 4'h0 || dma_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL dma_read_issue: got gnt=%b rstrb=%b wmask=%h rvalid=%b want 1/1/0/0",
               dma_gnt, mem_rstrb, mem_wmask, dma_rvalid);
    end
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    total++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h12345678 || dma_gnt !== 1'b0) begin
      bad++;
      $display("FAIL dma_read_data: got rvalid=%b rdata=%h gnt=%b want 1/12345678/0", dma_rvalid, dma_rdata, dma_gnt);
    end
    @(negedge clk);
    #1;
    total++;
    if (dma_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL dma_rvalid_pulse: got %b want 0", dma_rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_starve();
    drive_idle();
    cpu_wmask = 4'hF; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    drive_idle();
    cpu_rstrb = 1'b1; cpu_addr = 32'h20;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
`ifdef ARB_STARVE_EN
    begin
      int gnt_at;
      int rd_bad;
      gnt_at = -1;
      rd_bad = 0;
      for (int k = 0; k < int'(LIMIT) + 4 && gnt_at < 0; k++) begin
        #1;
        if (k > 0 && cpu_rdata !== 32'hCAFEF00D) rd_bad++;
        if (dma_gnt === 1'b1) begin
          gnt_at = k;
          total++;
          if (mem_rstrb !== 1'b1 || mem_addr !== 32'h80) begin
            bad++;
            $display("FAIL starve_dma_issue: got rstrb=%b addr=%h want 1/80", mem_rstrb, mem_addr);
          end
        end
        @(negedge clk);
      end
      total++;
      if (gnt_at != int'(LIMIT)) begin
        bad++;
        $display("FAIL starve_gnt_cycle: got request cycle %0d want %0d", gnt_at, LIMIT);
      end
      total++;
      if (rd_bad != 0) begin
        bad++;
        $display("FAIL starve_cpu_rdata: got %0d bad reads want 0", rd_bad);
      end
      // Replay cycle: CPU inputs here must be ignored.
      dma_req = 1'b0; cpu_addr = 32'h40; cpu_rstrb = 1'b1;
      #1;
      total++;
      if ({cpu_rbusy, cpu_wbusy, dma_gnt, mem_rstrb} !== 4'b1001 || mem_addr !== 32'h20) begin
        bad++;
        $display("FAIL replay_read_issue: got rbusy=%b wbusy=%b gnt=%b rstrb=%b addr=%h want 1/0/0/1/20",
                 cpu_rbusy, cpu_wbusy, dma_gnt, mem_rstrb, mem_addr);
      end
      total++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h12345678) begin
        bad++;
        $display("FAIL starve_dma_rdata: got rvalid=%b rdata=%h want 1/12345678", dma_rvalid, dma_rdata);
      end
      @(negedge clk);
      drive_idle();
      #1;
      total++;
      if (cpu_rdata !== 32'hCAFEF00D || cpu_rbusy !== 1'b0) begin
        bad++;
        $display("FAIL replay_read_data: got rdata=%h rbusy=%b want cafef00d/0", cpu_rdata, cpu_rbusy);
      end
      total++;
      if (mem_rstrb !== 1'b0) begin
        bad++;
        $display("FAIL replay_once: got rstrb=%b want 0", mem_rstrb);
      end
      @(negedge clk);
    end
`else
    begin
      int gnt_seen;
      int busy_seen;
      int rd_bad;
      gnt_seen = 0; busy_seen = 0; rd_bad = 0;
      for (int k = 0; k < 50; k++) begin
        #1;
        if (dma_gnt === 1'b1) gnt_seen++;
        if (cpu_rbusy !== 1'b0 || cpu_wbusy !== 1'b0) busy_seen++;
        if (k > 0 && cpu_rdata !== 32'hCAFEF00D) rd_bad++;
        @(negedge clk);
      end
      total++;
      if (gnt_seen != 0 || busy_seen != 0) begin
        bad++;
        $display("FAIL nosteal_gnt: got %0d grants %0d busy cycles want 0/0", gnt_seen, busy_seen);
      end
      total++;
      if (rd_bad != 0) begin
        bad++;
        $display("FAIL nosteal_cpu_rdata: got %0d bad reads want 0", rd_bad);
      end
      cpu_rstrb = 1'b0;
      #1;
      total++;
      if (dma_gnt !== 1'b1 || mem_rstrb !== 1'b1 || mem_addr !== 32'h80) begin
        bad++;
        $display("FAIL nosteal_idle_gnt: got gnt=%b rstrb=%b addr=%h want 1/1/80", dma_gnt, mem_rstrb, mem_addr);
      end
      @(negedge clk);
      dma_req = 1'b0;
      #1;
      total++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h12345678) begin
        bad++;
        $display("FAIL nosteal_dma_rdata: got rvalid=%b rdata=%h want 1/12345678", dma_rvalid, dma_rdata);
      end
      @(negedge clk);
    end
`endif
  endtask

`ifdef ARB_STARVE_EN
  task automatic test_collide_write();
    int gnt_at;
    logic [31:0] cpu_last;
    drive_idle();
    cpu_wmask = 4'hF; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10; dma_wdata = 32'hD0D0D0D0; dma_wmask = 4'hF;
    cpu_last = 32'h11110000 + LIMIT;
    gnt_at = -1;
    for (int k = 0; k < int'(LIMIT) + 4 && gnt_at < 0; k++) begin
      cpu_wdata = 32'h11110000 + 32'(k);
      #1;
      if (dma_gnt === 1'b1) begin
        gnt_at = k;
        total++;
        if (mem_wdata !== 32'hD0D0D0D0 || mem_wmask !== 4'hF || mem_addr !== 32'h10) begin
          bad++;
          $display("FAIL collide_dma_write: got wdata=%h wmask=%h addr=%h want d0d0d0d0/f/10", mem_wdata, mem_wmask, mem_addr);
        end
      end
      @(negedge clk);
    end
    total++;
    if (gnt_at != int'(LIMIT)) begin
      bad++;
      $display("FAIL collide_gnt_cycle: got %0d want %0d", gnt_at, LIMIT);
    end
    // Replay cycle with a fresh DMA read pending: it must not be granted.
    cpu_wmask = 4'h0; cpu_wdata = '0; dma_we = 1'b0;
    #1;
    total++;
    if ({dma_gnt, cpu_wbusy, cpu_rbusy} !== 3'b010 || mem_wmask !== 4'hF || mem_wdata !== cpu_last || mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL replay_write_issue: got gnt=%b wbusy=%b rbusy=%b wmask=%h wdata=%h addr=%h want 0/1/0/f/%h/10",
               dma_gnt, cpu_wbusy, cpu_rbusy, mem_wmask, mem_wdata, mem_addr, cpu_last);
    end
    @(negedge clk);
    #1;
    total++;
    if (dma_gnt !== 1'b1 || mem_rstrb !== 1'b1 || cpu_wbusy !== 1'b0) begin
      bad++;
      $display("FAIL collide_dma_read: got gnt=%b rstrb=%b wbusy=%b want 1/1/0", dma_gnt, mem_rstrb, cpu_wbusy);
    end
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    total++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== cpu_last) begin
      bad++;
      $display("FAIL collide_final_data: got rvalid=%b rdata=%h want 1/%h", dma_rvalid, dma_rdata, cpu_last);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_replay();
    int gnt_at;
    drive_idle();
    cpu_rstrb = 1'b1; cpu_addr = 32'h20;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
    gnt_at = -1;
    for (int k = 0; k < int'(LIMIT) + 4 && gnt_at < 0; k++) begin
      #1;
      if (dma_gnt === 1'b1) gnt_at = k;
      @(negedge clk);
    end
    total++;
    if (gnt_at != int'(LIMIT)) begin
      bad++;
      $display("FAIL midreplay_gnt_cycle: got %0d want %0d", gnt_at, LIMIT);
    end
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({mem_addr, mem_wdata, mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy} !== '0) begin
        bad++;
        $display("FAIL midreplay_reset c%0d: got addr=%h rstrb=%b wmask=%h gnt=%b rvalid=%b rbusy=%b wbusy=%b want all 0",
                 i, mem_addr, mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy);
      end
      @(negedge clk);
    end
    drive_idle();
    resetn = 1'b1;
    #1;
    total++;
    if ({mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy} !== '0) begin
      bad++;
      $display("FAIL midreplay_no_replay: got rstrb=%b wmask=%h gnt=%b rvalid=%b busy=%b%b want 0",
               mem_rstrb, mem_wmask, dma_gnt, dma_rvalid, cpu_rbusy, cpu_wbusy);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    bit          pend, p_rd, chk_cpu, chk_dma, dma_hold, act;
    bit          gnt_e, rstrb_e, rbusy_e, wbusy_e, rvalid_e;
    logic [31:0] p_addr, p_wdata, want_cpu, want_dma, addr_e, wdata_e;
    logic [3:0]  p_wmask, wmask_e;
    int unsigned waited;
    resetn = 1'b0;
    drive_idle();
    @(negedge clk);
    resetn = 1'b1;
    pend = 1'b0; p_rd = 1'b0; p_addr = '0; p_wdata = '0; p_wmask = '0;
    chk_cpu = 1'b0; chk_dma = 1'b0; want_cpu = '0; want_dma = '0;
    dma_hold = 1'b0; waited = 0;
    for (int i = 0; i < 1200; i++) begin
      // Stimulus: the first 16 cycles initialise the word window by CPU writes.
      cpu_wdata = $urandom;
      if (i < 16) begin
        cpu_rstrb = 1'b0; cpu_wmask = 4'hF; cpu_addr = 32'(i) << 2;
      end else begin
        cpu_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        case ($urandom_range(0, 3))
          0:       begin cpu_rstrb = 1'b0; cpu_wmask = 4'h0; end
          1, 2:    begin cpu_rstrb = 1'b1; cpu_wmask = 4'h0; end
          default: begin cpu_rstrb = 1'b0; cpu_wmask = 4'($urandom_range(1, 15)); end
        endcase
      end
      if (!dma_hold) begin
        dma_req   = (i >= 16) && ($urandom_range(0, 2) != 0);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        dma_wdata = $urandom;
        dma_wmask = 4'($urandom_range(1, 15));
      end
      #1;
      // Reference decision for this cycle.
      act = cpu_rstrb || (cpu_wmask != 4'h0);
      gnt_e = 1'b0; rbusy_e = 1'b0; wbusy_e = 1'b0; rvalid_e = chk_dma;
      if (pend) begin
        rstrb_e = p_rd; wmask_e = p_wmask; addr_e = p_addr; wdata_e = p_wdata;
        rbusy_e = p_rd; wbusy_e = !p_rd;
      end else if (dma_req && (!act || (STEAL && waited >= LIMIT))) begin
        gnt_e = 1'b1; rstrb_e = !dma_we; wmask_e = dma_we ? dma_wmask : 4'h0;
        addr_e = dma_addr; wdata_e = dma_wdata;
      end else begin
        rstrb_e = cpu_rstrb; wmask_e = cpu_wmask; addr_e = cpu_addr; wdata_e = cpu_wdata;
      end
      total++;
      if ({dma_gnt, mem_rstrb, mem_wmask, cpu_rbusy, cpu_wbusy, dma_rvalid} !==
          {gnt_e, rstrb_e, wmask_e, rbusy_e, wbusy_e, rvalid_e}) begin
        bad++;
        $display("FAIL rnd_ctrl c%0d: got gnt=%b rstrb=%b wmask=%h rbusy=%b wbusy=%b rvalid=%b want %b/%b/%h/%b/%b/%b",
                 i, dma_gnt, mem_rstrb, mem_wmask, cpu_rbusy, cpu_wbusy, dma_rvalid,
                 gnt_e, rstrb_e, wmask_e, rbusy_e, wbusy_e, rvalid_e);
      end
      if (rstrb_e || wmask_e != 4'h0) begin
        total++;
        if (mem_addr !== addr_e) begin
          bad++;
          $display("FAIL rnd_addr c%0d: got %h want %h", i, mem_addr, addr_e);
        end
      end
      if (wmask_e != 4'h0) begin
        total++;
        if (mem_wdata !== wdata_e) begin
          bad++;
          $display("FAIL rnd_wdata c%0d: got %h want %h", i, mem_wdata, wdata_e);
        end
      end
      if (chk_cpu) begin
        total++;
        if (cpu_rdata !== want_cpu) begin
          bad++;
          $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", i, cpu_rdata, want_cpu);
        end
      end
      if (chk_dma) begin
        total++;
        if (dma_rdata !== want_dma) begin
          bad++;
          $display("FAIL rnd_dma_rdata c%0d: got %h want %h", i, dma_rdata, want_dma);
        end
      end
      // Advance the reference.
      chk_cpu = 1'b0; chk_dma = 1'b0;
      if (rstrb_e) begin
        if (gnt_e) begin chk_dma = 1'b1; want_dma = ref_mem[addr_e[9:2]]; end
        else       begin chk_cpu = 1'b1; want_cpu = ref_mem[addr_e[9:2]]; end
      end
      for (int b = 0; b < 4; b++)
        if (wmask_e[b]) ref_mem[addr_e[9:2]][8*b +: 8] = wdata_e[8*b +: 8];
      if (!pend && gnt_e && act) begin
        pend = 1'b1; p_rd = cpu_rstrb; p_addr = cpu_addr; p_wdata = cpu_wdata; p_wmask = cpu_wmask;
      end else begin
        pend = 1'b0;
      end
      waited   = (!dma_req || gnt_e) ? 0 : waited + 1;
      dma_hold = dma_req && !gnt_e;
      @(negedge clk);
    end
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_cpu_only();
    test_dma_only();
    test_starve();
`ifdef ARB_STARVE_EN
    test_collide_write();
    test_reset_mid_replay();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
